// File: rtl/medfilt_pkg.sv
// Shared definitions for the median-filter frame scan datapath:
// scan FSM state encoding and default counter/address widths.
package medfilt_pkg;

  localparam int DIM_W_DEF  = 10;
  localparam int ADDR_W_DEF = 18;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_WIN  = 3'd2,
    WAIT_FILT = 3'd3,
    ADVANCE   = 3'd4,
    DONE      = 3'd5
  } scan_state_e;

endpackage

// File: rtl/frame_scan_ctrl_if.sv
// Pixel handshake between the scan controller (master), the window
// generator / median filter, and the result write port (slave side).
interface frame_scan_ctrl_if
  import medfilt_pkg::*;
#(
  parameter int DIM_W  = DIM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              win_start_sig;
  logic              win_done_sig;
  logic              filt_done_sig;
  logic [DIM_W-1:0]  column_addr_sig;
  logic [DIM_W-1:0]  row_addr_sig;
  logic              out_wr_en;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output win_start_sig, column_addr_sig, row_addr_sig, out_wr_en, out_addr,
    input  win_done_sig, filt_done_sig
  );

  modport slave (
    input  win_start_sig, column_addr_sig, row_addr_sig, out_wr_en, out_addr,
    output win_done_sig, filt_done_sig
  );

endinterface

// File: rtl/scan_addr_cnt.sv
// Row/column scan counters plus a running linear output address
// (row*cols + col maintained incrementally, no multiplier).
module scan_addr_cnt #(
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 18
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              clr,
  input  logic              adv,
  input  logic [DIM_W-1:0]  cols,
  input  logic [DIM_W-1:0]  rows,
  output logic [DIM_W-1:0]  col,
  output logic [DIM_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              last_pix
);

  logic [DIM_W-1:0] cols_q;
  logic [DIM_W-1:0] rows_q;
  logic             last_col;

  assign last_col = (col == cols_q - DIM_W'(1));
  assign last_pix = last_col && (row == rows_q - DIM_W'(1));

  // NOTE: non-blocking assignments so every update here sees pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cols_q <= '0;
      rows_q <= '0;
      col    <= '0;
      row    <= '0;
      addr   <= '0;
    end else if (clr) begin
      cols_q <= cols;
      rows_q <= rows;
      col    <= '0;
      row    <= '0;
      addr   <= '0;
    end else if (adv) begin
      addr <= addr + ADDR_W'(1);
      if (last_col) begin
        col <= '0;
        row <= row + DIM_W'(1);
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/frame_scan_ctrl.sv
// Frame scan controller: walks every pixel, handshakes window fetch and median
// result, emits result writes. Optional watchdog: define SCAN_WATCHDOG_EN.
module frame_scan_ctrl
  import medfilt_pkg::*;
#(
  parameter int DIM_W       = DIM_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start_sig,
  input  logic              abort_sig,
  input  logic [DIM_W-1:0]  cols,
  input  logic [DIM_W-1:0]  rows,
  frame_scan_ctrl_if.master pix,
  output logic              busy,
  output logic              frame_done_sig,
  output logic              err_sig
);

  scan_state_e       state_q, state_d;
  logic              cnt_clr, cnt_adv, last_pix, timeout, frame_done_q;
  logic [DIM_W-1:0]  col, row;
  logic [ADDR_W-1:0] addr;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("frame_scan_ctrl: TIMEOUT_CYC must be at least 1");
  end

  scan_addr_cnt #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_cnt (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .clr     (cnt_clr),
    .adv     (cnt_adv),
    .cols    (cols),
    .rows    (rows),
    .col     (col),
    .row     (row),
    .addr    (addr),
    .last_pix(last_pix)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= IDLE;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= (state_q == DONE) && !abort_sig;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_adv = 1'b0;
    if (abort_sig && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start_sig) begin
          cnt_clr = 1'b1;
          state_d = (cols == '0 || rows == '0) ? DONE : ISSUE;
        end
        ISSUE: state_d = WAIT_WIN;
        WAIT_WIN: begin
          if (pix.win_done_sig) state_d = pix.filt_done_sig ? ADVANCE : WAIT_FILT;
          else if (timeout)     state_d = DONE;
        end
        WAIT_FILT: begin
          if (pix.filt_done_sig) state_d = ADVANCE;
          else if (timeout)      state_d = DONE;
        end
        ADVANCE: begin
          cnt_adv = 1'b1;
          state_d = last_pix ? DONE : ISSUE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef SCAN_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q;
  logic            err_q;

  assign timeout = (state_q == WAIT_WIN || state_q == WAIT_FILT) &&
                   (wd_q == WD_W'(TIMEOUT_CYC - 1));
  assign err_sig = err_q;

  // Counts cycles spent in the current wait state; any transition restarts it.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_d != state_q || !(state_q == WAIT_WIN || state_q == WAIT_FILT))
        wd_q <= '0;
      else
        wd_q <= wd_q + WD_W'(1);
      if (cnt_clr)                       err_q <= 1'b0;
      else if (timeout && state_d == DONE) err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_sig = 1'b0;
`endif

  assign busy              = (state_q != IDLE);
  assign frame_done_sig    = frame_done_q;
  assign pix.win_start_sig = (state_q == ISSUE);
  assign pix.out_wr_en     = (state_q == ADVANCE);
  assign pix.out_addr      = addr;
  assign pix.column_addr_sig = col;
  assign pix.row_addr_sig    = row;

endmodule

// File: doc/frame_scan_ctrl.md
FRAME_SCAN_CTRL -- requirements
Module: frame_scan_ctrl

Interface
REQ-001 SHALL have parameter DIM_W, default 10: width of the row and column counters.
REQ-002 SHALL have parameter ADDR_W, default 18: width of the output pixel address.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255: watchdog limit in cycles.
REQ-004 SHALL have port CLK, in, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port RSTn, in, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port start_sig, in, 1: one-cycle frame start request.
REQ-007 SHALL have port abort_sig, in, 1: cancels the current frame.
REQ-008 SHALL have ports cols and rows, in, DIM_W each: image dimensions, sampled at start.
REQ-009 SHALL have port win_done_sig, in, 1: window generator has 9 pixels ready.
REQ-010 SHALL have port filt_done_sig, in, 1: median result valid.
REQ-011 SHALL have ports column_addr_sig and row_addr_sig, out, DIM_W each: centre pixel coordinates.
REQ-012 SHALL have port win_start_sig, out, 1: one-cycle pulse that starts window fetch.
REQ-013 SHALL have ports out_wr_en (out, 1) and out_addr (out, ADDR_W): result write strobe and address.
REQ-014 SHALL have ports busy (out, 1), frame_done_sig (out, 1, pulse) and err_sig (out, 1, sticky).

Function
REQ-015 SHALL implement the states IDLE, ISSUE, WAIT_WIN, WAIT_FILT, ADVANCE and DONE.
REQ-016 IDLE with start_sig=1: SHALL latch cols/rows, clear row, col, out_addr and err_sig, then go to ISSUE; if either latched dimension is 0, SHALL go to DONE instead.
REQ-017 ISSUE: SHALL assert win_start_sig for exactly 1 cycle with coordinates stable, then go to WAIT_WIN.
REQ-018 WAIT_WIN: on win_done_sig SHALL go to WAIT_FILT; if filt_done_sig arrives in the same cycle, SHALL go directly to ADVANCE and perform the write.
REQ-019 WAIT_FILT: on filt_done_sig SHALL pulse out_wr_en for 1 cycle, with out_addr = row*cols + col, then go to ADVANCE.
REQ-020 out_addr SHALL be a running counter incremented once per write; no multiplier.
REQ-021 ADVANCE wrap rules:
  - col == cols-1: SHALL set col = 0 and row += 1.
  - Otherwise: SHALL set col += 1.
  - Last pixel (row == rows-1 and col == cols-1): SHALL go to DONE; otherwise to ISSUE.
REQ-022 DONE: SHALL pulse frame_done_sig for 1 cycle, then return to IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 start_sig while busy SHALL be ignored.
REQ-025 abort_sig in any non-IDLE state SHALL force IDLE on the next edge, with no frame_done_sig and no further out_wr_en; abort_sig has priority over all handshakes.
REQ-026 Per-pixel latency from win_start_sig to out_wr_en SHALL be (win latency + filter latency + 1) cycles; ADVANCE-to-ISSUE SHALL take 1 cycle.

Reset
REQ-027 On RSTn=0: state = IDLE; all outputs = 0; counters = 0; err_sig = 0; takes effect immediately, including mid-frame.

Configuration
REQ-028 With SCAN_WATCHDOG_EN defined:
  - A cycle counter SHALL run in WAIT_WIN and WAIT_FILT.
  - Reaching TIMEOUT_CYC SHALL set err_sig and go to DONE.
  - The counter SHALL clear on every state change.
REQ-029 Without SCAN_WATCHDOG_EN: no watchdog logic; err_sig tied 0; the wait states wait indefinitely.

Structure
REQ-030 The state encoding typedef and the default DIM_W/ADDR_W constants SHALL live in shared package medfilt_pkg.
REQ-031 The row/column/address counters SHALL be a sub-module, scan_addr_cnt; the FSM stays in the top level.

Verification
REQ-032 4x3 frame, window and filter each responding 2 cycles after request: 12 out_wr_en pulses, out_addr 0..11 in order, then 1 frame_done_sig pulse.
REQ-033 win_done_sig and filt_done_sig in the same cycle: exactly one write, no stall.
REQ-034 abort_sig asserted after the 5th write: busy low on the next cycle, no frame_done_sig, total writes = 5.
REQ-035 cols = 0: frame_done_sig 2 cycles after start_sig, no win_start_sig.
REQ-036 start_sig pulsed mid-frame: ignored, no counter reset.
REQ-037 With SCAN_WATCHDOG_EN and TIMEOUT_CYC = 8, win_done_sig never asserted: err_sig = 1 and frame_done_sig after 8 cycles in WAIT_WIN.
